conv_pointwise_2d_scheduler: RTL and testbench
==============================================

// Module: conv_pointwise_2d_scheduler
// PURPOSE
//  Sequencer for the pointwise (1x1) 2D conv MAC datapath. On start, walks every
//  (pixel, out_ch, in_ch) triple; issues input/weight buffer addresses and MAC clear/enable/last strobes.
//  Presents each finished accumulator to a ready/valid output port.
//  Sits between the layer controller (cfg/start/done) and the MAC + buffer SRAMs.
// PARAMETERS
//  MAX_IN_CH   64    max input channels (sizes ci counter)
//  MAX_OUT_CH  64    max output channels (sizes co counter)
//  MAX_PIX     4096  max H*W pixels (sizes pixel counter)
//  MAC_LAT     2     cycles from mac_en issue to accumulator result valid
//  AW          18    buffer address width; >= clog2(MAX_PIX*MAX_IN_CH), >= clog2(MAX_OUT_CH*MAX_IN_CH)
// PORTS
//  clk         in   1     clock, all logic on rising edge
//  rst         in   1     synchronous reset, active-high
//  start       in   1     1-cycle pulse; accepted only in IDLE
//  cfg_in_ch   in   CW_I  input channel count, CW_I=clog2(MAX_IN_CH+1); sampled at start
//  cfg_out_ch  in   CW_O  output channel count, CW_O=clog2(MAX_OUT_CH+1); sampled at start
//  cfg_pix     in   CW_P  pixel count H*W, CW_P=clog2(MAX_PIX+1); sampled at start
//  busy        out  1     high from cycle after accepted start until done
//  done        out  1     1-cycle pulse at job end
//  in_addr     out  AW    input buffer read address = pix*in_ch + ci
//  w_addr      out  AW    weight buffer read address = co*in_ch + ci
//  rd_en       out  1     buffer read strobe (same cycle as in_addr/w_addr)
//  mac_clear   out  1     with first mac_en of an output: load product, discard accumulator
//  mac_en      out  1     MAC accumulate enable, MAC_LAT-aligned with rd_en per datapath contract
//  mac_last    out  1     with final mac_en of an output
//  out_valid   out  1     accumulator result ready for consumer
//  out_ready   in   1     consumer accepts when out_valid & out_ready
//  out_pix     out  CW_P  pixel index of presented result
//  out_ch      out  CW_O  output channel index of presented result
// BEHAVIOUR
//  Reset: state=IDLE; all counters/bases 0; busy, done, rd_en, mac_* and out_valid 0; addresses 0.
//  Loop order: pix outer, co middle, ci inner (input pixel vector reused across all co).
//  No multipliers: pix_base += in_ch per pixel; co_base += in_ch per co, cleared per pixel;
//   in_addr = pix_base + ci, w_addr = co_base + ci.
//  FSM states:
//   IDLE : start & all cfg != 0 -> latch cfg, ISSUE.
//          start & any cfg == 0 -> done pulse next cycle, stay IDLE, no rd_en/mac activity.
//   ISSUE: rd_en=mac_en=1 each cycle, ci 0..in_ch-1; mac_clear at ci==0; mac_last at ci==in_ch-1.
//          After last issue -> FLUSH.
//   FLUSH: MAC_LAT cycles, no strobes -> OUT.
//   OUT  : out_valid=1; out_pix/out_ch stable until handshake; stall indefinitely on out_ready=0.
//          On handshake: co<out_ch-1 -> co++, ISSUE.
//          else pix<pix-1 -> co=0, pix++, ISSUE.
//          else -> DONE.
//   DONE : done=1 one cycle, busy drops same cycle -> IDLE.
//  Latency per output: in_ch + MAC_LAT + 1 cycles when out_ready=1.
//  Total job: pix*out_ch*(in_ch+MAC_LAT+1) + 1 cycles, start to done.
//  start while busy: ignored; cfg changes mid-job: ignored.
//  rst mid-job: immediate return to IDLE next edge; no done; out_valid drops.
//  in_ch==1: mac_clear and mac_last asserted in the same cycle.
//  Counter wrap: none; terminal compares use latched cfg. cfg above MAX_* is out of contract.
// STRUCTURE
//  Shared package conv_pw_pkg: state enum (IDLE, ISSUE, FLUSH, OUT, DONE), MAX_* defaults, CW_* helpers.
//  One sub-module conv_pw_addr_gen: ci counter + pix_base/co_base adders, emitting in_addr/w_addr.
//  FSM and output register in the top.
// TESTING
//  T1 in_ch=3, out_ch=2, pix=2, out_ready=1, MAC_LAT=2 -> 4 results in (0,0),(0,1),(1,0),(1,1) order;
//     done at cycle 25 after start; in_addr seq 0,1,2,0,1,2,3,4,5,3,4,5; w_addr 0,1,2,3,4,5 repeated.
//  T2 in_ch=1, out_ch=1, pix=1 -> one issue cycle with mac_clear=mac_last=1; out_valid 3 cycles later; done next.
//  T3 out_ready=0 for 10 cycles in first OUT -> out_valid, out_pix=0, out_ch=0 held; no rd_en; resume on ready.
//  T4 cfg_out_ch=0 with start -> done pulse next cycle; busy, rd_en, mac_en stay 0.
//  T5 second start during busy -> ignored; job completes with original cfg; single done.
//  T6 rst asserted mid-ISSUE -> next cycle all outputs 0, IDLE; new start runs T1 correctly.

Source files
------------

// File: rtl/conv_pointwise_2d_scheduler_pkg.sv
// Shared types and defaults for the pointwise 1x1 conv scheduler.
package conv_pw_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_FLUSH = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DEF_MAX_IN_CH  = 64;
  localparam int DEF_MAX_OUT_CH = 64;
  localparam int DEF_MAX_PIX    = 4096;
  localparam int DEF_MAC_LAT    = 2;
  localparam int DEF_AW         = 18;

  // Width of a counter that must hold the value n itself (not just 0..n-1).
  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/conv_pointwise_2d_scheduler_if.sv
// Result stream from the scheduler to the accumulator consumer.
// Handshake: a transfer happens on a rising edge where out_valid & out_ready are both 1;
// while out_valid is 1 and no transfer has happened, out_pix/out_ch hold and out_valid stays 1.
interface conv_pointwise_2d_scheduler_if #(
  parameter int CW_P = 13,
  parameter int CW_O = 7
);
  logic            out_valid;
  logic            out_ready;
  logic [CW_P-1:0] out_pix;
  logic [CW_O-1:0] out_ch;

  modport master (output out_valid, output out_pix, output out_ch, input out_ready);
  modport slave  (input out_valid, input out_pix, input out_ch, output out_ready);
endinterface

// File: rtl/conv_pointwise_2d_scheduler_addr_gen.sv
// Input-channel counter plus running pixel/output-channel bases; addresses are base + ci,
// so no multiplier is needed.
module conv_pw_addr_gen #(
  parameter int AW   = 18,
  parameter int CW_I = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            step,
  input  logic            next_co,
  input  logic            next_pix,
  input  logic [CW_I-1:0] in_ch,
  output logic [AW-1:0]   in_addr,
  output logic [AW-1:0]   w_addr,
  output logic            ci_first,
  output logic            ci_last
);

  logic [CW_I-1:0] ci_q;
  logic [AW-1:0]   pix_base_q;
  logic [AW-1:0]   co_base_q;

  assign ci_first = (ci_q == '0);
  assign ci_last  = (ci_q == in_ch - CW_I'(1));
  assign in_addr  = pix_base_q + AW'(ci_q);
  assign w_addr   = co_base_q + AW'(ci_q);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ci_q       <= '0;
      pix_base_q <= '0;
      co_base_q  <= '0;
    end else begin
      if (step) ci_q <= ci_last ? '0 : ci_q + CW_I'(1);
      // Moving to a new pixel restarts the weight walk from output channel 0.
      if (next_pix) begin
        pix_base_q <= pix_base_q + AW'(in_ch);
        co_base_q  <= '0;
      end else if (next_co) begin
        co_base_q  <= co_base_q + AW'(in_ch);
      end
    end
  end

endmodule

// File: rtl/conv_pointwise_2d_scheduler.sv
// Pointwise conv sequencer: walks pix / out_ch / in_ch, drives buffer reads and MAC strobes,
// and presents each finished accumulator on the result stream.
module conv_pointwise_2d_scheduler
  import conv_pw_pkg::*;
#(
  parameter int MAX_IN_CH  = DEF_MAX_IN_CH,
  parameter int MAX_OUT_CH = DEF_MAX_OUT_CH,
  parameter int MAX_PIX    = DEF_MAX_PIX,
  parameter int MAC_LAT    = DEF_MAC_LAT,
  parameter int AW         = DEF_AW,
  localparam int CW_I      = cw_of(MAX_IN_CH),
  localparam int CW_O      = cw_of(MAX_OUT_CH),
  localparam int CW_P      = cw_of(MAX_PIX)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CW_I-1:0] cfg_in_ch,
  input  logic [CW_O-1:0] cfg_out_ch,
  input  logic [CW_P-1:0] cfg_pix,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   in_addr,
  output logic [AW-1:0]   w_addr,
  output logic            rd_en,
  output logic            mac_clear,
  output logic            mac_en,
  output logic            mac_last,
  output state_t          state_dbg,
  conv_pointwise_2d_scheduler_if.master res
);

  localparam int FW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  state_t          state_q, state_d;
  logic [CW_I-1:0] in_ch_q;
  logic [CW_O-1:0] out_ch_q, co_q;
  logic [CW_P-1:0] pix_q, pix_cnt_q;
  logic [FW-1:0]   flush_q;
  logic            zero_done_q;
  logic            cfg_ok, start_ok, hs, co_last, pix_last, flush_last;
  logic            ci_first, ci_last;

  assign cfg_ok     = (cfg_in_ch != '0) && (cfg_out_ch != '0) && (cfg_pix != '0);
  assign start_ok   = (state_q == S_IDLE) && start && cfg_ok;
  assign hs         = (state_q == S_OUT) && res.out_ready;
  assign co_last    = (co_q == out_ch_q - CW_O'(1));
  assign pix_last   = (pix_cnt_q == pix_q - CW_P'(1));
  assign flush_last = (flush_q == FW'(MAC_LAT - 1));
  assign state_dbg  = state_q;

  conv_pw_addr_gen #(.AW(AW), .CW_I(CW_I)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .step     (state_q == S_ISSUE),
    .next_co  (hs && !co_last),
    .next_pix (hs && co_last && !pix_last),
    .in_ch    (in_ch_q),
    .in_addr  (in_addr),
    .w_addr   (w_addr),
    .ci_first (ci_first),
    .ci_last  (ci_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ch_q     <= '0;
      out_ch_q    <= '0;
      pix_q       <= '0;
      co_q        <= '0;
      pix_cnt_q   <= '0;
      flush_q     <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      // A start with an empty dimension completes immediately without touching the datapath.
      zero_done_q <= (state_q == S_IDLE) && start && !cfg_ok;
      flush_q     <= (state_q == S_FLUSH) ? flush_q + FW'(1) : '0;
      if (start_ok) begin
        in_ch_q   <= cfg_in_ch;
        out_ch_q  <= cfg_out_ch;
        pix_q     <= cfg_pix;
        co_q      <= '0;
        pix_cnt_q <= '0;
      end else if (hs && !co_last) begin
        co_q      <= co_q + CW_O'(1);
      end else if (hs && !pix_last) begin
        co_q      <= '0;
        pix_cnt_q <= pix_cnt_q + CW_P'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_ISSUE;
      S_ISSUE: if (ci_last) state_d = S_FLUSH;
      S_FLUSH: if (flush_last) state_d = S_OUT;
      S_OUT:   if (res.out_ready) state_d = (co_last && pix_last) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = zero_done_q;
    rd_en         = 1'b0;
    mac_en        = 1'b0;
    mac_clear     = 1'b0;
    mac_last      = 1'b0;
    res.out_valid = 1'b0;
    case (state_q)
      S_ISSUE: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        mac_en    = 1'b1;
        mac_clear = ci_first;
        mac_last  = ci_last;
      end
      S_FLUSH: busy = 1'b1;
      S_OUT: begin
        busy          = 1'b1;
        res.out_valid = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign res.out_pix = pix_cnt_q;
  assign res.out_ch  = co_q;

endmodule

// File: tb/tb_conv_pointwise_2d_scheduler.sv
// Self-checking bench: table of jobs with expected done latency, scoreboards for the
// issue stream and the result stream, plus hand-written stall/restart/reset sequences.
module tb_conv_pointwise_2d_scheduler;
  import conv_pw_pkg::*;

  localparam int AW = 18, CW_I = 7, CW_O = 7, CW_P = 13;

  logic            clk, rst, start;
  logic [CW_I-1:0] cfg_in_ch;
  logic [CW_O-1:0] cfg_out_ch;
  logic [CW_P-1:0] cfg_pix;
  logic            busy, done, rd_en, mac_clear, mac_en, mac_last;
  logic [AW-1:0]   in_addr, w_addr;
  state_t          state_dbg;

  conv_pointwise_2d_scheduler_if #(.CW_P(CW_P), .CW_O(CW_O)) res ();

  conv_pointwise_2d_scheduler dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch), .cfg_pix(cfg_pix),
    .busy(busy), .done(done), .in_addr(in_addr), .w_addr(w_addr),
    .rd_en(rd_en), .mac_clear(mac_clear), .mac_en(mac_en), .mac_last(mac_last),
    .state_dbg(state_dbg), .res(res)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // scoreboard state
  int n_cmp = 0;
  int n_fail = 0;
  int t0 = 0;
  logic [37:0] addr_q[$];
  logic [19:0] exp_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Issue and result monitors
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en || mac_en) begin
        check("mac_en_eq_rd_en", 32'(mac_en), 32'(rd_en));
        if (addr_q.size() == 0) begin
          check("unexpected_issue", 32'(addr_q.size()), 32'd1);
        end else begin
          logic [37:0] e;
          e = addr_q.pop_front();
          check("mac_clear", 32'(mac_clear), 32'(e[37]));
          check("mac_last", 32'(mac_last), 32'(e[36]));
          check("in_addr", 32'(in_addr), 32'(e[35:18]));
          check("w_addr", 32'(w_addr), 32'(e[17:0]));
        end
      end
      if (res.out_valid && res.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [19:0] r;
          r = exp_q.pop_front();
          check("out_pix", 32'(res.out_pix), 32'(r[19:7]));
          check("out_ch", 32'(res.out_ch), 32'(r[6:0]));
        end
      end
    end
  end

  // driver tasks
  task automatic start_job(input int ic, input int oc, input int px);
    @(posedge clk); #1;
    cfg_in_ch  = CW_I'(ic);
    cfg_out_ch = CW_O'(oc);
    cfg_pix    = CW_P'(px);
    start      = 1'b1;
    if (ic != 0 && oc != 0 && px != 0) begin
      for (int p = 0; p < px; p++)
        for (int co = 0; co < oc; co++) begin
          for (int ci = 0; ci < ic; ci++)
            addr_q.push_back({(ci == 0), (ci == ic - 1), 18'(p * ic + ci), 18'(co * ic + ci)});
          exp_q.push_back({13'(p), 7'(co)});
        end
    end
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc_cnt;
    // Scramble cfg after the start edge; the job must keep its latched values.
    cfg_in_ch  = CW_I'($urandom_range(1, 64));
    cfg_out_ch = CW_O'($urandom_range(1, 64));
    cfg_pix    = CW_P'($urandom_range(1, 4096));
  endtask

  task automatic wait_done(input int exp_cyc, input bit rnd, input bit exp_busy);
    int  c;
    bit  got;
    c = 0;
    got = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      c = cyc_cnt - t0 + 1;
      if (c == 1) check("busy_cycle1", 32'(busy), 32'(exp_busy));
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (rnd) res.out_ready = 1'($urandom_range(0, 1));
    end
    check("done_seen", 32'(got), 32'd1);
    if (got && exp_cyc >= 0) check("done_cycle", 32'(c), 32'(exp_cyc));
    check("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    res.out_ready = 1'b1;
    check("issue_q_drained", 32'(addr_q.size()), 32'd0);
    check("result_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 32'(state_dbg), 32'(S_IDLE));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_mac"}, 32'({mac_en, mac_clear, mac_last}), 32'd0);
    check({tag, "_out_valid"}, 32'(res.out_valid), 32'd0);
    check({tag, "_in_addr"}, 32'(in_addr), 32'd0);
    check({tag, "_w_addr"}, 32'(w_addr), 32'd0);
  endtask

  typedef struct {
    int in_ch;
    int out_ch;
    int pix;
    bit rnd;
    int exp_cyc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3, 2, 2, 1'b0, 25};
    vecs[1] = '{1, 1, 1, 1'b0, 5};
    vecs[2] = '{2, 3, 1, 1'b0, 16};
    vecs[3] = '{4, 1, 3, 1'b0, 22};
    vecs[4] = '{2, 0, 2, 1'b0, 1};
    vecs[5] = '{0, 3, 3, 1'b0, 1};
    vecs[6] = '{1, 2, 3, 1'b0, 25};
    vecs[7] = '{64, 2, 1, 1'b0, 135};
    vecs[8] = '{3, 3, 2, 1'b1, -1};
    vecs[9] = '{5, 2, 2, 1'b1, -1};

    rst = 1'b1;
    start = 1'b0;
    cfg_in_ch = '0;
    cfg_out_ch = '0;
    cfg_pix = '0;
    res.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      start_job(vecs[v].in_ch, vecs[v].out_ch, vecs[v].pix);
      wait_done(vecs[v].exp_cyc, vecs[v].rnd,
                (vecs[v].in_ch != 0) && (vecs[v].out_ch != 0) && (vecs[v].pix != 0));
    end

    // Consumer stalls the first result for 10 cycles
    res.out_ready = 1'b0;
    start_job(3, 2, 2);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (res.out_valid) begin
          seen = 1'b1;
          break;
        end
      end
      check("stall_valid_seen", 32'(seen), 32'd1);
      for (int k = 0; k < 10; k++) begin
        check("stall_valid", 32'(res.out_valid), 32'd1);
        check("stall_pix", 32'(res.out_pix), 32'd0);
        check("stall_ch", 32'(res.out_ch), 32'd0);
        check("stall_rd_en", 32'(rd_en), 32'd0);
        @(negedge clk);
      end
      @(posedge clk); #1;
      res.out_ready = 1'b1;
      wait_done(-1, 1'b0, 1'b1);
    end

    // Second start while busy is ignored
    start_job(2, 2, 1);
    repeat (3) @(posedge clk);
    #1;
    cfg_in_ch = 7'd4;
    cfg_out_ch = 7'd4;
    cfg_pix = 13'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(11, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_second_job_busy", 32'(busy), 32'd0);
      check("no_second_done", 32'(done), 32'd0);
    end

    // Reset in the middle of ISSUE, then a clean rerun
    start_job(3, 2, 2);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    addr_q.delete();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_idle("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    start_job(3, 2, 2);
    wait_done(25, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
